// File: rtl/max_pool_2x2_if.sv
// rtl/max_pool_2x2_if.sv - pixel stream and pooled-result bundle for max_pool_2x2
interface max_pool_2x2_if #(
    parameter int N = 16
);
    logic [N-1:0] conv_in;
    logic         valid_in;
    logic         end_in;
    logic [N-1:0] pool_op;
    logic         valid_pool;
    logic         end_pool;
    logic         frame_err;

    modport master (
        output conv_in,
        output valid_in,
        output end_in,
        input  pool_op,
        input  valid_pool,
        input  end_pool,
        input  frame_err
    );

    modport slave (
        input  conv_in,
        input  valid_in,
        input  end_in,
        output pool_op,
        output valid_pool,
        output end_pool,
        output frame_err
    );
endinterface

// File: rtl/max_pool_2x2.sv
// rtl/max_pool_2x2.sv - streaming 2x2 stride-2 max pooling with half-width line buffer
module max_pool_2x2 #(
    parameter int N    = 16,
    parameter int Q    = 12,
    parameter int M    = 2,
    parameter int RELU = 0
) (
    input  logic          clk,
    input  logic          global_rst,
    input  logic          ce,
    max_pool_2x2_if.slave bus
);
    // Counter and line-buffer index widths; kept at least one bit wide for M=2.
    localparam int CW   = (M > 2) ? $clog2(M) : 1;
    localparam int HALF = M / 2;
    localparam int JW   = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [CW-1:0] LAST = CW'(M - 1);

    // Fixed-point 0.0 in the QN.Q format used by the clamp.
    localparam logic [N-1:0] FIXED_ZERO = N'(0) << Q;

    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic [N-1:0]  temp;
    logic [N-1:0]  lbuf [HALF];

    logic          accept;
    logic          at_last;
    logic          early_end;
    logic          win_done;
    logic [JW-1:0] j;
    logic [N-1:0]  result;

    function automatic logic [N-1:0] smax(input logic [N-1:0] a, input logic [N-1:0] b);
        smax = ($signed(a) >= $signed(b)) ? a : b;
    endfunction

    function automatic logic [N-1:0] relu(input logic [N-1:0] v);
        if (RELU != 0 && v[N-1]) begin
            relu = FIXED_ZERO;
        end else begin
            relu = v;
        end
    endfunction

    // Decode the accepted pixel's position within the map and its pooling role.
    always_comb begin
        accept    = ce & bus.valid_in;
        at_last   = (row == LAST) && (col == LAST);
        early_end = accept & bus.end_in & ~at_last;
        win_done  = accept & row[0] & col[0];
        j         = JW'(col >> 1);
        result    = smax(temp, bus.conv_in);
    end

    // Raster position; an early end_in resyncs both counters to the next map.
    always_ff @(posedge clk) begin
        if (global_rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (early_end) begin
                col <= '0;
                row <= '0;
            end else if (col == LAST) begin
                col <= '0;
                row <= (row == LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Horizontal pair max into lbuf on even rows; fold lbuf into temp on odd rows.
    always_ff @(posedge clk) begin
        if (global_rst) begin
            temp <= '0;
            for (int k = 0; k < HALF; k++) begin
                lbuf[k] <= '0;
            end
        end else if (accept) begin
            if (!row[0]) begin
                if (!col[0]) begin
                    temp <= bus.conv_in;
                end else begin
                    lbuf[j] <= smax(temp, bus.conv_in);
                end
            end else if (!col[0]) begin
                temp <= smax(lbuf[j], bus.conv_in);
            end
        end
    end

    // Register the pooled result; pulses drop whenever no window completes.
    always_ff @(posedge clk) begin
        if (global_rst) begin
            bus.pool_op    <= '0;
            bus.valid_pool <= 1'b0;
            bus.end_pool   <= 1'b0;
        end else begin
            bus.valid_pool <= win_done;
            bus.end_pool   <= win_done & at_last;
            if (win_done) begin
                bus.pool_op <= relu(result);
            end
        end
    end

    // Sticky framing error for end_in seen anywhere but the last map position.
    always_ff @(posedge clk) begin
        if (global_rst) begin
            bus.frame_err <= 1'b0;
        end else if (early_end) begin
            bus.frame_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_max_pool_2x2.sv
// tb/tb_max_pool_2x2.sv - directed table-driven bench for max_pool_2x2
module tb_max_pool_2x2;
    localparam int N = 16;
    localparam int M = 4;

    logic clk = 1'b0;
    logic global_rst;
    logic ce;

    max_pool_2x2_if #(.N(N)) bus0 ();
    max_pool_2x2_if #(.N(N)) bus1 ();

    max_pool_2x2 #(.N(N), .Q(12), .M(M), .RELU(0)) dut0 (
        .clk        (clk),
        .global_rst (global_rst),
        .ce         (ce),
        .bus        (bus0.slave)
    );

    max_pool_2x2 #(.N(N), .Q(12), .M(M), .RELU(1)) dut1 (
        .clk        (clk),
        .global_rst (global_rst),
        .ce         (ce),
        .bus        (bus1.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         ce;
        logic         vin;
        logic         en;
        logic [N-1:0] data;
        logic         ev;
        logic         ee;
        logic [N-1:0] ed;
        logic [N-1:0] edr;
    } vec_t;

    vec_t         vecs[$];
    logic [N-1:0] obs_vals[$];
    logic         obs_ends[$];
    logic [N-1:0] exp_vals[$];
    logic         exp_ends[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic c, input logic v, input logic e, input logic [N-1:0] d,
                                input logic ev, input logic ee, input logic [N-1:0] ed,
                                input logic [N-1:0] edr);
        vec_t r;
        r.ce = c; r.vin = v; r.en = e; r.data = d;
        r.ev = ev; r.ee = ee; r.ed = ed; r.edr = edr;
        vecs.push_back(r);
    endfunction

    // Ascending ramp: each window's max is its bottom-right pixel (indices 5, 7, 13, 15).
    function automatic void add_ramp(input int base);
        for (int i = 0; i < 16; i++) begin
            logic ev;
            ev = (i == 5) || (i == 7) || (i == 13) || (i == 15);
            add(1'b1, 1'b1, i == 15, N'(base + i), ev, i == 15, N'(base + i), N'(base + i));
        end
    endfunction

    task automatic drive(input logic c, input logic v, input logic e, input logic [N-1:0] d);
        ce            = c;
        bus0.valid_in = v; bus1.valid_in = v;
        bus0.end_in   = e; bus1.end_in   = e;
        bus0.conv_in  = d; bus1.conv_in  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic run_pixels(input int base, input int n, input int end_idx);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b1, i == end_idx, N'(base + i));
            if (bus0.valid_pool) begin
                obs_vals.push_back(bus0.pool_op);
                obs_ends.push_back(bus0.end_pool);
            end else if (bus0.end_pool) begin
                obs_vals.push_back('1);
                obs_ends.push_back(1'b1);
            end
        end
    endtask

    task automatic compare_obs(input string name);
        check({name, " count"}, obs_vals.size(), exp_vals.size());
        for (int i = 0; i < exp_vals.size(); i++) begin
            if (i < obs_vals.size()) begin
                check($sformatf("%s out%0d", name, i), obs_vals[i], exp_vals[i]);
                check($sformatf("%s end%0d", name, i), obs_ends[i], exp_ends[i]);
            end
        end
        obs_vals.delete(); obs_ends.delete();
        exp_vals.delete(); exp_ends.delete();
    endtask

    initial begin
        // Map 1: plain ramp 0..15.
        add_ramp(0);

        // Map 2: signed compare window, remaining pixels most negative.
        for (int i = 0; i < 16; i++) begin
            logic [N-1:0] d;
            logic         ev;
            logic [N-1:0] ed;
            logic [N-1:0] edr;
            d = 16'h8000;
            if (i == 1) d = 16'h7FFF;
            if (i == 4) d = 16'hFFFF;
            if (i == 5) d = 16'h0001;
            ev  = (i == 5) || (i == 7) || (i == 13) || (i == 15);
            ed  = (i == 5) ? 16'h7FFF : 16'h8000;
            edr = (i == 5) ? 16'h7FFF : 16'h0000;
            add(1'b1, 1'b1, i == 15, d, ev, i == 15, ed, edr);
        end

        // Map 3: all -1; ReLU variant clamps to zero.
        for (int i = 0; i < 16; i++) begin
            logic ev;
            ev = (i == 5) || (i == 7) || (i == 13) || (i == 15);
            add(1'b1, 1'b1, i == 15, 16'hFFFF, ev, i == 15, 16'hFFFF, 16'h0000);
        end

        // Map 4: ramp with ce stall after pixel 6 and valid gap after pixel 9.
        for (int i = 0; i < 16; i++) begin
            logic ev;
            ev = (i == 5) || (i == 7) || (i == 13) || (i == 15);
            add(1'b1, 1'b1, i == 15, N'(i), ev, i == 15, N'(i), N'(i));
            if (i == 6) begin
                for (int s = 0; s < 3; s++) add(1'b0, 1'b1, 1'b1, 16'h7777, 1'b0, 1'b0, '0, '0);
            end
            if (i == 9) begin
                for (int s = 0; s < 2; s++) add(1'b1, 1'b0, 1'b1, 16'h7777, 1'b0, 1'b0, '0, '0);
            end
        end

        // Maps 5 and 6: back-to-back ramps with no gap.
        add_ramp(0);
        add_ramp(16);

        // Reset while ce=0 and a valid pixel is presented.
        global_rst = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 16'h1234);
        drive(1'b1, 1'b1, 1'b1, 16'h1234);
        global_rst = 1'b0;
        check("rst pool_op",    bus0.pool_op,    0);
        check("rst valid_pool", bus0.valid_pool, 0);
        check("rst end_pool",   bus0.end_pool,   0);
        check("rst frame_err",  bus0.frame_err,  0);
        check("rst relu pool_op", bus1.pool_op,  0);

        foreach (vecs[k]) begin
            drive(vecs[k].ce, vecs[k].vin, vecs[k].en, vecs[k].data);
            check($sformatf("vec%0d valid_pool", k), bus0.valid_pool, vecs[k].ev);
            check($sformatf("vec%0d end_pool", k),   bus0.end_pool,   vecs[k].ee);
            check($sformatf("vec%0d relu valid", k), bus1.valid_pool, vecs[k].ev);
            if (vecs[k].ev) begin
                check($sformatf("vec%0d pool_op", k),      bus0.pool_op, vecs[k].ed);
                check($sformatf("vec%0d relu pool_op", k), bus1.pool_op, vecs[k].edr);
            end
        end
        check("table frame_err", bus0.frame_err, 0);

        // Early end at pixel 9.
        run_pixels(0, 9, -1);
        check("pre early frame_err", bus0.frame_err, 0);
        run_pixels(9, 1, 0);
        check("early frame_err", bus0.frame_err, 1);
        exp_vals = '{16'd5, 16'd7};
        exp_ends = '{1'b0, 1'b0};
        compare_obs("early");
        run_pixels(0, 16, 15);
        exp_vals = '{16'd5, 16'd7, 16'd13, 16'd15};
        exp_ends = '{1'b0, 1'b0, 1'b0, 1'b1};
        compare_obs("resync");
        check("resync frame_err sticky", bus0.frame_err, 1);

        // Reset after pixel 6 of a map carrying large values.
        run_pixels(100, 7, -1);
        obs_vals.delete(); obs_ends.delete();
        global_rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            drive(1'b1, 1'b1, 1'b0, 16'h7000);
            check($sformatf("midrst%0d pool_op", s),    bus0.pool_op,    0);
            check($sformatf("midrst%0d valid_pool", s), bus0.valid_pool, 0);
            check($sformatf("midrst%0d end_pool", s),   bus0.end_pool,   0);
            check($sformatf("midrst%0d frame_err", s),  bus0.frame_err,  0);
        end
        global_rst = 1'b0;
        run_pixels(0, 16, 15);
        exp_vals = '{16'd5, 16'd7, 16'd13, 16'd15};
        exp_ends = '{1'b0, 1'b0, 1'b0, 1'b1};
        compare_obs("after reset");
        check("after reset frame_err", bus0.frame_err, 0);

        drive(1'b1, 1'b0, 1'b0, '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/max_pool_2x2.md
Name: max_pool_2x2

Overview:
Streaming 2x2, stride-2 max-pooling stage directly downstream of the convolver. It consumes the convolver's raster-ordered feature-map pixels (conv_op / valid_conv / end_conv) and emits one pooled pixel per 2x2 window in raster order. ReLU can optionally be applied to each pooled result. A half-width line buffer holds partial row maxima, so there is no frame storage.

Parameters:
- N, 16, word width; signed two's-complement fixed point.
- Q, 12, fractional bits. Carried for consistency only; does not affect the comparison.
- M, 2, input feature-map width and height; equals (n-k)/s+1 of the convolver. Must be even and at least 2.
- RELU, 0, when 1, negative pooled results are clamped to 0 at the output.

Ports:
- clk, input, 1, clock; all logic on the rising edge.
- global_rst, input, 1, synchronous active-high reset.
- ce, input, 1, clock enable. When 0, no state advances.
- conv_in, input, N, feature-map pixel from the convolver (conv_op).
- valid_in, input, 1, conv_in is valid this cycle (valid_conv).
- end_in, input, 1, marks the last pixel of a map (end_conv); qualified by valid_in.
- pool_op, output, N, pooled pixel.
- valid_pool, output, 1, one-cycle pulse: pool_op is valid.
- end_pool, output, 1, one-cycle pulse coincident with the last pooled pixel of a map.
- frame_err, output, 1, sticky flag: end_in arrived at the wrong position.

Behaviour:
- Reset: global_rst sampled high at a rising edge sets the following:
  - col=0, row=0;
  - line buffer and window temp all cleared to 0;
  - pool_op=0, valid_pool=0, end_pool=0, frame_err=0.
  - Reset overrides ce and any in-flight input.
  - Reset mid-map discards the partial map; the next valid pixel is treated as (row 0, col 0).
- Accept: a pixel is accepted only when ce=1 and valid_in=1. Inputs are ignored otherwise.
- Counters:
  - col runs 0..M-1. It wraps to 0 and row increments on col=M-1.
  - row runs 0..M-1. It wraps to 0 after (M-1, M-1).
- Even row, let j=col/2:
  - even col: temp <= conv_in.
  - odd col: lbuf[j] <= smax(temp, conv_in).
- Odd row, let j=col/2:
  - even col: temp <= smax(lbuf[j], conv_in).
  - odd col: result = smax(temp, conv_in). Register pool_op <= relu(result), valid_pool <= 1.
  - end_pool <= 1 iff row=M-1 and col=M-1.
- smax: signed compare over N bits. On a tie, either operand (identical values).
- relu: returns 0 if RELU=1 and the value is negative, otherwise the value unchanged.
- Latency: pool_op and valid_pool are registered one cycle after the accepting edge of the window's 4th pixel (odd row, odd col).
- Output registers:
  - valid_pool and end_pool are 0 in every cycle with no new result, including when ce=0.
  - pool_op holds its last value between results.
- Throughput: one input per cycle sustained, no stalls. Back-to-back maps need no gap; row/col wrap seamlessly.
- end_in accepted at (M-1, M-1): normal end of map; no error.
- end_in accepted at any other position:
  - frame_err <= 1;
  - the pixel is processed normally, but no output is produced for an incomplete window;
  - col and row then force to 0, i.e. resync to the next map.
- Pixel accepted at (M-1, M-1) without end_in: normal output, end_pool=1, frame_err unaffected.
- frame_err clears only on global_rst.
- ce low mid-map: counters, temp and lbuf hold. The stream resumes exactly where it stopped.

Test Plan:
- M=4, RELU=0: reset, then feed 0..15 raster, one per cycle with ce=1, valid_in=1, end_in on 15. Required response:
  - valid_pool pulses with pool_op = 5, 7, 13, 15, each one cycle after pixels 5, 7, 13, 15 respectively;
  - end_pool only with 15;
  - frame_err=0.
- M=4, signed compare: window pixels 0x8000, 0x7FFF, 0xFFFF, 0x0001 at (0,0),(0,1),(1,0),(1,1), with other pixels 0x8000. Required: first output 0x7FFF. Then all 16 pixels 0xFFFF: every output is 0xFFFF with RELU=0, and 0x0000 with RELU=1.
- M=4, stall: repeat the first scenario with ce=0 for 3 cycles after pixel 6 and valid_in=0 for 2 cycles after pixel 9. Required:
  - same outputs 5, 7, 13, 15;
  - no valid_pool during stall cycles;
  - exactly 4 pulses total.
- Back-to-back maps: feed 0..15, then 16..31 with no gap. Required outputs 5, 7, 13, 15, 21, 23, 29, 31, with end_pool on 15 and on 31.
- Early end: M=4, assert end_in with pixel index 9. Required:
  - frame_err=1 from the next cycle;
  - outputs 5 and 7 only;
  - the next pixels 0..15 produce 5, 7, 13, 15 normally, and frame_err stays 1 until global_rst.
- Reset mid-map: global_rst after pixel 6, then feed 0..15. Required: outputs 0 and pulses 0 during reset; afterwards exactly 5, 7, 13, 15, with no stale lbuf contribution.
